// File: rtl/ldst_coalesce_multi.sv
// Multi-entry ld/st coalescer: merges same-line thread commands into up to NUM_ENTRIES open
// cache-line entries and emits closed entries strictly in allocation order.
module ldst_coalesce_multi #(
   parameter int CACHE_LINE_SIZE        = 32,
   parameter int NUM_MAX_COALESCED_CMDS = CACHE_LINE_SIZE / 4,
   parameter int BASE_ADDR_OFFSET       = $clog2(CACHE_LINE_SIZE),
   parameter int NUM_ENTRIES            = 4,
   parameter int TIMEOUT                = 16
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               incmd_valid,
   output logic                                               incmd_ready,
   input  logic [3:0]                                         incmd_block_id,
   input  logic [9:0]                                         incmd_tid,
   input  logic                                               incmd_write_enable,
   input  logic [63:0]                                        incmd_write_data,
   input  logic [7:0]                                         incmd_write_mask,
   input  logic [63:0]                                        incmd_address,
   input  logic [1:0]                                         incmd_size,
   input  logic [6:0]                                         incmd_ld_dest_reg,
   input  logic                                               flush,
   output logic                                               outcmd_valid,
   input  logic                                               outcmd_ready,
   output logic [3:0]                                         outcmd_block_id,
   output logic [9:0]                                         outcmd_base_tid,
   output logic [NUM_MAX_COALESCED_CMDS-1:0]                  outcmd_tid_bitmap,
   output logic                                               outcmd_write_enable,
   output logic [CACHE_LINE_SIZE*8-1:0]                       outcmd_write_data,
   output logic [CACHE_LINE_SIZE-1:0]                         outcmd_write_mask,
   output logic [63:0]                                        outcmd_address,
   output logic [1:0]                                         outcmd_size,
   output logic [6:0]                                         outcmd_ld_dest_reg,
   output logic [NUM_MAX_COALESCED_CMDS*BASE_ADDR_OFFSET-1:0] outcmd_address_map,
   output logic                                               idle
);

   localparam int NS     = NUM_MAX_COALESCED_CMDS;
   localparam int LB     = CACHE_LINE_SIZE;
   localparam int DW     = LB * 8;
   localparam int MAP_W  = NS * BASE_ADDR_OFFSET;
   localparam int SLOT_W = (NS > 1) ? $clog2(NS) : 1;
   localparam int IDX_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int CNT_W  = $clog2(NUM_ENTRIES + 1);
   localparam int AGE_W  = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_FREE   = 2'd0;
   localparam logic [1:0] ST_OPEN   = 2'd1;
   localparam logic [1:0] ST_CLOSED = 2'd2;

   typedef struct packed {
      logic [1:0]       st;
      logic [3:0]       blk;
      logic [9:0]       base;
      logic [NS-1:0]    bmp;
      logic             we;
      logic [DW-1:0]    data;
      logic [LB-1:0]    mask;
      logic [63:0]      addr;
      logic [1:0]       size;
      logic [6:0]       dest;
      logic [MAP_W-1:0] map;
      logic [AGE_W-1:0] age;
   } entry_t;

   entry_t           ent_q [NUM_ENTRIES];
   entry_t           ent_d [NUM_ENTRIES];
   logic [IDX_W-1:0] ord_q [NUM_ENTRIES];
   logic [IDX_W-1:0] ord_d [NUM_ENTRIES];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [63:0]                 in_line;
   logic [BASE_ADDR_OFFSET-1:0] in_off;
   logic [9:0]                  in_base;
   logic [SLOT_W-1:0]           in_slot;
   logic [DW-1:0]               in_data_sh, in_bits;
   logic [LB-1:0]               in_mask_sh;

   logic             hit_any, col_any, free_any, ev_any;
   logic [IDX_W-1:0] hit_idx, col_idx, free_idx, ev_idx, head;
   logic             acc, do_merge, do_alloc, evict, pop;

   assign in_line    = incmd_address & ~64'(LB - 1);
   assign in_off     = incmd_address[BASE_ADDR_OFFSET-1:0];
   assign in_base    = incmd_tid & ~10'(NS - 1);
   assign in_slot    = SLOT_W'(incmd_tid - in_base);
   assign in_data_sh = DW'(incmd_write_data) << {in_off, 3'b000};
   assign in_mask_sh = LB'(incmd_write_mask) << in_off;

   always_comb begin
      in_bits = '0;
      for (int unsigned b = 0; b < LB; b++) in_bits[b*8 +: 8] = {8{in_mask_sh[b]}};
   end

   // Descending scans so the lowest index (or oldest queue position) wins.
   always_comb begin
      hit_any  = 1'b0; hit_idx  = '0;
      col_any  = 1'b0; col_idx  = '0;
      free_any = 1'b0; free_idx = '0;
      ev_any   = 1'b0; ev_idx   = '0;
      for (int unsigned e = NUM_ENTRIES; e > 0; e--) begin
         if (ent_q[e-1].st == ST_OPEN && ent_q[e-1].blk == incmd_block_id &&
             ent_q[e-1].addr == in_line && ent_q[e-1].we == incmd_write_enable &&
             ent_q[e-1].size == incmd_size && ent_q[e-1].dest == incmd_ld_dest_reg &&
             ent_q[e-1].base == in_base) begin
            if (ent_q[e-1].bmp[in_slot]) begin
               col_any = 1'b1; col_idx = IDX_W'(e - 1);
            end else begin
               hit_any = 1'b1; hit_idx = IDX_W'(e - 1);
            end
         end
         if (ent_q[e-1].st == ST_FREE) begin
            free_any = 1'b1; free_idx = IDX_W'(e - 1);
         end
         if (CNT_W'(e - 1) < cnt_q && ent_q[ord_q[e-1]].st == ST_OPEN) begin
            ev_any = 1'b1; ev_idx = ord_q[e-1];
         end
      end
   end

   assign head         = ord_q[0];
   assign incmd_ready  = !rst && (hit_any || free_any);
   assign acc          = incmd_valid && incmd_ready;
   assign do_merge     = acc && hit_any;
   assign do_alloc     = acc && !hit_any;
   assign evict        = incmd_valid && !rst && !hit_any && !free_any && ev_any;
   assign outcmd_valid = !rst && (cnt_q != '0) && (ent_q[head].st == ST_CLOSED);
   assign pop          = outcmd_valid && outcmd_ready;

   always_comb begin
      for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
         ent_d[e] = ent_q[e];
         if (ent_q[e].st == ST_OPEN && ent_q[e].age != AGE_W'(TIMEOUT))
            ent_d[e].age = ent_q[e].age + 1'b1;
      end
      if (do_merge) begin
         ent_d[hit_idx].bmp[in_slot] = 1'b1;
         ent_d[hit_idx].map[in_slot*BASE_ADDR_OFFSET +: BASE_ADDR_OFFSET] = in_off;
         ent_d[hit_idx].age = '0;
         if (incmd_write_enable) begin
            ent_d[hit_idx].data = (ent_q[hit_idx].data & ~in_bits) | (in_data_sh & in_bits);
            ent_d[hit_idx].mask = ent_q[hit_idx].mask | in_mask_sh;
         end
      end
      if (do_alloc && col_any) ent_d[col_idx].st = ST_CLOSED;
      if (do_alloc) begin
         ent_d[free_idx].st   = ST_OPEN;
         ent_d[free_idx].blk  = incmd_block_id;
         ent_d[free_idx].base = in_base;
         ent_d[free_idx].bmp  = '0;
         ent_d[free_idx].bmp[in_slot] = 1'b1;
         ent_d[free_idx].we   = incmd_write_enable;
         ent_d[free_idx].data = incmd_write_enable ? (in_data_sh & in_bits) : '0;
         ent_d[free_idx].mask = incmd_write_enable ? in_mask_sh : '0;
         ent_d[free_idx].addr = in_line;
         ent_d[free_idx].size = incmd_size;
         ent_d[free_idx].dest = incmd_ld_dest_reg;
         ent_d[free_idx].map  = '0;
         ent_d[free_idx].map[in_slot*BASE_ADDR_OFFSET +: BASE_ADDR_OFFSET] = in_off;
         ent_d[free_idx].age  = '0;
      end
      if (evict) ent_d[ev_idx].st = ST_CLOSED;
      // Close checks run on the post-accept image so a same-cycle flush also closes the new entry.
      for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
         if (ent_d[e].st == ST_OPEN &&
             ((&ent_d[e].bmp) || ent_d[e].age >= AGE_W'(TIMEOUT) || flush))
            ent_d[e].st = ST_CLOSED;
      end
      if (pop) ent_d[head].st = ST_FREE;
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) ord_d[i] = ord_q[i];
      cnt_d = cnt_q;
      if (pop) begin
         for (int unsigned i = 0; i + 1 < NUM_ENTRIES; i++) ord_d[i] = ord_q[i+1];
         ord_d[NUM_ENTRIES-1] = '0;
         cnt_d = cnt_q - 1'b1;
      end
      if (do_alloc) begin
         for (int unsigned i = 0; i < NUM_ENTRIES; i++)
            if (CNT_W'(i) == cnt_d) ord_d[i] = free_idx;
         cnt_d = cnt_d + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
            ent_q[e] <= '0;
            ord_q[e] <= '0;
         end
         cnt_q <= '0;
      end else begin
         for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
            ent_q[e] <= ent_d[e];
            ord_q[e] <= ord_d[e];
         end
         cnt_q <= cnt_d;
      end
   end

   assign outcmd_block_id     = outcmd_valid ? ent_q[head].blk  : '0;
   assign outcmd_base_tid     = outcmd_valid ? ent_q[head].base : '0;
   assign outcmd_tid_bitmap   = outcmd_valid ? ent_q[head].bmp  : '0;
   assign outcmd_write_enable = outcmd_valid ? ent_q[head].we   : 1'b0;
   assign outcmd_write_data   = outcmd_valid ? ent_q[head].data : '0;
   assign outcmd_write_mask   = outcmd_valid ? ent_q[head].mask : '0;
   assign outcmd_address      = outcmd_valid ? ent_q[head].addr : '0;
   assign outcmd_size         = outcmd_valid ? ent_q[head].size : '0;
   assign outcmd_ld_dest_reg  = outcmd_valid ? ent_q[head].dest : '0;
   assign outcmd_address_map  = outcmd_valid ? ent_q[head].map  : '0;

   always_comb begin
      idle = 1'b1;
      for (int unsigned e = 0; e < NUM_ENTRIES; e++)
         if (ent_q[e].st != ST_FREE) idle = 1'b0;
   end

endmodule
